mem_responder: RTL
==================

# mem_responder

Unified single-port byte memory that serves the CPU's instruction-fetch and data ports and drives `inst_mem_stall` / `data_mem_stall` back into the pipeline. It sits under `Top` as the `memory` instance. It arbitrates both request ports onto one backing array `mem`, applies a fixed access latency, and returns registered read data. The array is byte-wide so `$readmemh` images and byte-wise dumps (for example `mem[16'h8000+i]`) address it directly.

## Interface
- `ADDR_W`, 16: byte-address width; the array is `mem[0:(1<<ADDR_W)-1]`, 8 bits per entry.
- `LATENCY`, 2: wait cycles per access, legal range 1..15.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `inst_req` in 1: fetch request; held until completion.
- `inst_addr` in 32: fetch byte address.
- `inst_rdata` out 32: fetched word, little-endian.
- `inst_mem_stall` out 1: fetch not complete this cycle.
- `data_req` in 1: load/store request; held until completion.
- `data_we` in 1: 1 = store.
- `data_wstrb` in 4: byte enables; bit k writes byte addr+k.
- `data_addr` in 32: data byte address.
- `data_wdata` in 32: store data.
- `data_rdata` out 32: load data.
- `data_mem_stall` out 1: data access not complete this cycle.
- `bound_err` out 1: sticky out-of-range flag (see Configuration).

## Operation
- FSM states:
  - IDLE
  - BUSY_I, BUSY_D: counter `cnt`, 4 bits
  - DONE_I, DONE_D
- Grant (IDLE only):
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port not granted last time wins. `last_grant` resets to inst, so data wins the first tie.
  - The granted port's addr, we, wstrb and wdata are latched at grant; later input changes are ignored.
- Address: bits [1:0] forced to 0 (word aligned). Word = {mem[a+3], mem[a+2], mem[a+1], mem[a]}.
- BUSY_x: `cnt` loaded with LATENCY-1 at grant and decremented each cycle.
  - On the edge where `cnt`==0, the array access executes and state moves to DONE_x.
  - Load: `x_rdata` <= word.
  - Store: `data_rdata` <= the pre-write word (read-before-write), then the enabled bytes are written.
- DONE_x: the completion cycle for port x; next state is IDLE.
- Stalls are combinational:
  - `inst_mem_stall` = `inst_req` && !(state==DONE_I).
  - `data_mem_stall` = `data_req` && !(state==DONE_D).
  - A port waiting while the other port is served stays stalled.
- `x_rdata` holds its value until that port's next access completes.
- Request deasserted mid-access is a protocol violation. The access still completes (a store still commits) and the FSM returns to IDLE with no further effect.
- Addresses with bits above ADDR_W set alias onto the array (upper bits ignored), unless the bounds-check feature is compiled in.

## Timing
- Grant in cycle T (IDLE, req=1). Stall is high in cycles T..T+LATENCY and low in completion cycle T+LATENCY+1, so there are LATENCY+1 stall cycles.
- Read data is valid in the completion cycle. A store is visible to any access granted after it.
- Next grant is no earlier than T+LATENCY+2, giving a throughput of one access per LATENCY+2 cycles.
- Reset values:
  - state IDLE, `cnt` 0, `last_grant` inst.
  - `inst_rdata` 0, `data_rdata` 0, `bound_err` 0.
  - Stalls follow req (high whenever req=1, since state is IDLE).
- `mem` is never cleared by reset.
- Reset mid-access aborts it. A store whose commit edge has not occurred is not written.
- Reset asserted on the commit edge takes priority: no write, `rdata` 0.

## Configuration
- `MEM_RESPONDER_BOUNDS_CHECK_EN` defined:
  - A latched address with any bit [31:ADDR_W] set is out of range.
  - An out-of-range load returns 32'hDEAD_BEEF.
  - An out-of-range store writes nothing and returns 32'hDEAD_BEEF on `data_rdata`.
  - `bound_err` is set at the access edge and stays set until reset.
  - Timing is unchanged.
- Macro not defined: upper address bits are ignored (aliasing) and `bound_err` is tied to 0.

## Test plan
- Fetch from preloaded mem[0..3]=13,05,00,00 at addr 0x0, LATENCY=2 -> `inst_mem_stall` high 3 cycles, then low with `inst_rdata`=32'h0000_0513.
- Store 32'hAABBCCDD to 0x8000 with wstrb=4'b0101, then load 0x8000 (prior contents 0) -> mem[8000..8003]=DD,00,BB,00; load returns 32'h00BB00DD.
- `inst_req` and `data_req` both rise from reset in the same cycle -> data completes at T+3 while fetch stays stalled; fetch is granted at T+4 and completes at T+7.
- Assert `rst` during BUSY_D of a store of 32'h12345678 to 0x8010 -> mem[8010..8013] unchanged, stalls follow req, `data_rdata`=0.
- Load from address 0x0001_8004 -> with the macro, 32'hDEAD_BEEF and `bound_err`=1; without it, returns the mem[0x8004] word and `bound_err`=0.
- LATENCY=1, back-to-back fetches of 0x0 then 0x4 -> each shows 2 stall cycles; completions are 3 cycles apart.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - unified byte memory serving fetch and data ports with fixed latency
// Optional bounds checking of the upper address bits: MEM_RESPONDER_BOUNDS_CHECK_EN.
module mem_responder #(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_mem_stall,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_mem_stall,
  output logic        bound_err
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  state_t      state;
  logic [3:0]  cnt;
  logic        last_grant;  // 0 = inst, 1 = data
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;
  logic        lat_we;
  logic        bound_q;

  logic [ADDR_W-3:0] widx;
  logic [31:0]       word;
  logic              oor;
  logic              access;
  logic              store;
  logic              grant_d;
  logic              unused_addr_bits;

  assign widx = lat_addr[ADDR_W-1:2];
  assign word = {mem[{widx, 2'd3}], mem[{widx, 2'd2}], mem[{widx, 2'd1}], mem[{widx, 2'd0}]};
  assign unused_addr_bits = ^{lat_addr[31:ADDR_W], lat_addr[1:0]};

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
  assign oor = |lat_addr[31:ADDR_W];
`else
  assign oor = 1'b0;
`endif

  assign access  = (state == BUSY_I || state == BUSY_D) && cnt == 4'd0;
  assign store   = state == BUSY_D && cnt == 4'd0 && lat_we && !oor;
  // On a tie the port that lost last time wins.
  assign grant_d = data_req && (!inst_req || !last_grant);

  assign inst_mem_stall = inst_req && state != DONE_I;
  assign data_mem_stall = data_req && state != DONE_D;
  assign bound_err      = bound_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_wstrb  <= 4'd0;
      lat_we     <= 1'b0;
      inst_rdata <= 32'd0;
      data_rdata <= 32'd0;
      bound_q    <= 1'b0;
    end else begin
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
      if (access && oor) bound_q <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (inst_req || data_req) begin
            cnt        <= 4'(LATENCY - 1);
            last_grant <= grant_d;
            if (grant_d) begin
              state     <= BUSY_D;
              lat_addr  <= data_addr;
              lat_we    <= data_we;
              lat_wstrb <= data_wstrb;
              lat_wdata <= data_wdata;
            end else begin
              state    <= BUSY_I;
              lat_addr <= inst_addr;
              lat_we   <= 1'b0;
            end
          end
        end
        BUSY_I: begin
          if (cnt == 4'd0) begin
            inst_rdata <= oor ? 32'hDEAD_BEEF : word;
            state      <= DONE_I;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        BUSY_D: begin
          if (cnt == 4'd0) begin
            data_rdata <= oor ? 32'hDEAD_BEEF : word;
            state      <= DONE_D;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE_I, DONE_D: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The array is never reset; a reset coinciding with the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && store) begin
      for (int k = 0; k < 4; k++) begin
        if (lat_wstrb[k]) mem[{widx, 2'(k)}] <= lat_wdata[8*k +: 8];
      end
    end
  end

endmodule
